// File: rtl/keccak_lane_buffer.sv
// Lane-stream endpoint: absorbs 64-bit lanes into the SHA3 rate buffer, drives the permutation
// start/done handshake and streams the digest out. Define KECCAK_PAD_EN for hardware SHA3 padding.
module keccak_lane_buffer #(
   parameter int RATE_LANES = 17,
   parameter int OUT_LANES  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [63:0]                din,
   input  logic                       din_valid,
   input  logic                       last_block,
   output logic                       buffer_full,
   output logic                       ready,
   output logic [63:0]                dout,
   output logic                       dout_valid,
   output logic                       perm_start,
   output logic                       perm_last,
   output logic [64*RATE_LANES-1:0]   block_o,
   input  logic                       perm_done,
   input  logic [64*OUT_LANES-1:0]    digest_i
);

   localparam int CW = $clog2(RATE_LANES + 1);
   localparam int AW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
   localparam int IW = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(RATE_LANES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABSORB,
      S_PAD,
      S_PERM,
      S_SQUEEZE
   } state_t;

   state_t              r_state;
   logic [63:0]         r_buf [RATE_LANES];
   logic [63:0]         r_dig [OUT_LANES];
   logic [CW-1:0]       r_cnt;
   logic [IW-1:0]       r_idx;
   logic                r_last_pend;
   logic                r_perm_start;
   logic                r_perm_last;
   logic                r_dout_valid;
   logic [63:0]         r_dout;

   logic                w_full;
   logic                w_ready;
   logic [AW-1:0]       w_idx;
   logic [64*RATE_LANES-1:0] w_block;

   assign w_full  = (r_cnt == CNT_FULL);
   assign w_ready = ((r_state == S_IDLE) || (r_state == S_ABSORB)) && !w_full;
   assign w_idx   = AW'(r_cnt);

   always_comb begin
      w_block = '0;
      for (int unsigned i = 0; i < RATE_LANES; i++) begin
         w_block[64*i +: 64] = r_buf[i];
      end
   end

   assign buffer_full = w_full;
   assign ready       = w_ready;
   assign block_o     = w_block;
   assign perm_start  = r_perm_start;
   assign perm_last   = r_perm_last;
   assign dout        = r_dout;
   assign dout_valid  = r_dout_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_last_pend  <= 1'b0;
         r_perm_start <= 1'b0;
         r_perm_last  <= 1'b0;
         r_dout_valid <= 1'b0;
         r_dout       <= '0;
         for (int unsigned i = 0; i < RATE_LANES; i++) r_buf[i] <= '0;
         for (int unsigned i = 0; i < OUT_LANES; i++)  r_dig[i] <= '0;
      end else begin
         r_perm_start <= 1'b0;
         r_dout_valid <= 1'b0;
         r_dout       <= '0;
         // start wins in every state; a lane strobed alongside it lands in lane 0
         if (start) begin
            for (int unsigned i = 0; i < RATE_LANES; i++) r_buf[i] <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_last_pend <= 1'b0;
            r_perm_last <= 1'b0;
            if (din_valid) begin
               r_buf[0] <= din;
               r_cnt    <= CW'(1);
            end
            r_state <= last_block ? S_PAD : S_ABSORB;
         end else begin
            case (r_state)
               S_IDLE: ;
               S_ABSORB: begin
                  if (din_valid && !w_full) begin
                     r_buf[w_idx] <= din;
                     r_cnt        <= r_cnt + CW'(1);
                  end
                  if (last_block) begin
                     r_state <= S_PAD;
                  end else if (w_full) begin
                     r_state      <= S_PERM;
                     r_perm_start <= 1'b1;
                     r_perm_last  <= 1'b0;
                  end
               end
               S_PAD: begin
                  r_state      <= S_PERM;
                  r_perm_start <= 1'b1;
`ifdef KECCAK_PAD_EN
                  // a message ending exactly on a block boundary needs an extra padding-only block
                  if (w_full) begin
                     r_last_pend <= 1'b1;
                     r_perm_last <= 1'b0;
                  end else begin
                     r_buf[w_idx][7:0]              <= r_buf[w_idx][7:0] ^ 8'h06;
                     r_buf[RATE_LANES-1][63:56]     <= r_buf[RATE_LANES-1][63:56] ^ 8'h80;
                     r_last_pend                    <= 1'b0;
                     r_perm_last                    <= 1'b1;
                  end
`else
                  r_perm_last <= 1'b1;
`endif
               end
               S_PERM: begin
                  if (perm_done) begin
                     if (r_perm_last) begin
                        for (int unsigned i = 0; i < OUT_LANES; i++) begin
                           r_dig[i] <= digest_i[64*i +: 64];
                        end
                        r_idx       <= '0;
                        r_perm_last <= 1'b0;
                        r_state     <= S_SQUEEZE;
                     end else begin
                        for (int unsigned i = 0; i < RATE_LANES; i++) r_buf[i] <= '0;
                        r_cnt   <= '0;
                        r_state <= r_last_pend ? S_PAD : S_ABSORB;
                     end
                  end
               end
               S_SQUEEZE: begin
                  r_dout       <= r_dig[r_idx];
                  r_dout_valid <= 1'b1;
                  r_idx        <= r_idx + IW'(1);
                  if (r_idx == IW'(OUT_LANES - 1)) r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keccak_lane_buffer.sv
// Bench for keccak_lane_buffer: random lanes, a behavioural block/padding model and a
// responding permutation core; padding expectations follow KECCAK_PAD_EN.
module tb_keccak_lane_buffer;

   localparam int RL = 17;
   localparam int OL = 4;
   localparam int BW = 64 * RL;
`ifdef KECCAK_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [63:0]     din;
   logic            din_valid;
   logic            last_block;
   logic            buffer_full;
   logic            ready;
   logic [63:0]     dout;
   logic            dout_valid;
   logic            perm_start;
   logic            perm_last;
   logic [BW-1:0]   block_o;
   logic            perm_done;
   logic [64*OL-1:0] digest_i;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int perm_lat_fix = 0;

   logic [BW-1:0]    blk_q[$];
   logic [BW-1:0]    eblk_q[$];
   bit               pl_q[$];
   bit               epl_q[$];
   logic [64*OL-1:0] dig_q[$];
   logic [63:0]      dout_q[$];
   int               dv_cyc[$];
   logic [63:0]      exp_lanes[$];

   keccak_lane_buffer #(.RATE_LANES(RL), .OUT_LANES(OL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .din        (din),
      .din_valid  (din_valid),
      .last_block (last_block),
      .buffer_full(buffer_full),
      .ready      (ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .perm_start (perm_start),
      .perm_last  (perm_last),
      .block_o    (block_o),
      .perm_done  (perm_done),
      .digest_i   (digest_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // output monitor
   always @(negedge clk) begin
      if (dout_valid === 1'b1) begin
         dout_q.push_back(dout);
         dv_cyc.push_back(cyc);
      end
   end

   // permutation core: snapshots the block, answers after a few cycles with a fresh digest
   initial begin
      perm_done = 1'b0;
      digest_i  = '0;
      forever begin
         @(negedge clk);
         if (perm_start === 1'b1) begin
            int lat;
            bit pl;
            logic [64*OL-1:0] d;
            blk_q.push_back(block_o);
            pl = perm_last;
            pl_q.push_back(pl);
            lat = (perm_lat_fix != 0) ? perm_lat_fix : int'($urandom_range(1, 4));
            repeat (lat) @(negedge clk);
            for (int k = 0; k < 2*OL; k++) d[32*k +: 32] = $urandom;
            digest_i  = d;
            perm_done = 1'b1;
            if (pl) dig_q.push_back(d);
            @(negedge clk);
            perm_done = 1'b0;
            for (int k = 0; k < 2*OL; k++) digest_i[32*k +: 32] = $urandom;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_blk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      for (int i = 0; i < RL; i++) begin
         chk($sformatf("%s_lane%0d", tag, i), obs[64*i +: 64], exp[64*i +: 64]);
      end
   endtask

   // Expected permutation blocks for one message: full blocks of lanes, then the final block
   function automatic void model(input bit last, input bit stand);
      int L, nfull, rem;
      bit ff;
      logic [BW-1:0] blk;
      L     = exp_lanes.size();
      nfull = L / RL;
      rem   = L % RL;
      ff    = last && !stand && (rem == 0) && (L > 0) && !PAD;
      for (int b = 0; b < nfull; b++) begin
         blk = '0;
         for (int i = 0; i < RL; i++) blk[64*i +: 64] = exp_lanes[b*RL + i];
         eblk_q.push_back(blk);
         epl_q.push_back(ff && (b == nfull - 1));
      end
      if (last && !ff) begin
         blk = '0;
         for (int i = 0; i < rem; i++) blk[64*i +: 64] = exp_lanes[nfull*RL + i];
         if (PAD) begin
            blk[64*rem +: 8]         = blk[64*rem +: 8] ^ 8'h06;
            blk[64*(RL-1) + 56 +: 8] = blk[64*(RL-1) + 56 +: 8] ^ 8'h80;
         end
         eblk_q.push_back(blk);
         epl_q.push_back(1'b1);
      end
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (ready !== 1'b1 && w < 400) begin
         tick();
         w++;
      end
      chk("ready_wait", ready, 64'd1);
   endtask

   task automatic drive_lane(input logic [63:0] d, input bit lst, input bit st);
      if (!st) wait_ready();
      din        = d;
      din_valid  = 1'b1;
      last_block = lst;
      start      = st;
      tick();
      din        = '0;
      din_valid  = 1'b0;
      last_block = 1'b0;
      start      = 1'b0;
   endtask

   task automatic drive_last_only();
      wait_ready();
      last_block = 1'b1;
      tick();
      last_block = 1'b0;
   endtask

   task automatic check_blocks(input string tag);
      int w;
      w = 0;
      while (blk_q.size() < eblk_q.size() && w < 400) begin
         tick();
         w++;
      end
      chk({tag, "_nblk"}, 64'(blk_q.size()), 64'(eblk_q.size()));
      for (int i = 0; i < eblk_q.size() && i < blk_q.size(); i++) begin
         chk_blk($sformatf("%s_b%0d", tag, i), blk_q[i], eblk_q[i]);
         chk($sformatf("%s_b%0d_plast", tag, i), 64'(pl_q[i]), 64'(epl_q[i]));
      end
      blk_q.delete();
      eblk_q.delete();
      pl_q.delete();
      epl_q.delete();
   endtask

   task automatic check_digest(input string tag);
      int w;
      logic [64*OL-1:0] d;
      w = 0;
      while (dout_q.size() < OL && w < 400) begin
         tick();
         w++;
      end
      repeat (3) tick();
      chk({tag, "_nlanes"}, 64'(dout_q.size()), 64'(OL));
      chk({tag, "_ndig"}, 64'(dig_q.size()), 64'd1);
      d = (dig_q.size() > 0) ? dig_q.pop_front() : '0;
      for (int k = 0; k < OL && k < dout_q.size(); k++) begin
         chk($sformatf("%s_dout%0d", tag, k), dout_q[k], d[64*k +: 64]);
      end
      if (dout_q.size() == OL) chk({tag, "_consec"}, 64'(dv_cyc[OL-1] - dv_cyc[0]), 64'(OL - 1));
      dout_q.delete();
      dv_cyc.delete();
      dig_q.delete();
   endtask

   task automatic run_msg(input int n, input bit last, input bit stand, input int pat, input string tag);
      exp_lanes.delete();
      for (int i = 0; i < n; i++) begin
         exp_lanes.push_back((pat == 1) ? 64'(i + 1) : (pat == 2) ? 64'h61 : {$urandom, $urandom});
      end
      model(last, stand);
      if (n == 0) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end else begin
         for (int i = 0; i < n; i++) drive_lane(exp_lanes[i], last && !stand && (i == n - 1), i == 0);
      end
      if (last && stand) drive_last_only();
      check_blocks(tag);
      if (last) check_digest(tag);
   endtask

   initial begin
      int w, seen, n;
      bit stand;
      logic [63:0] lane1;
      logic [64*OL-1:0] d;

      rst_n = 1'b0; start = 1'b0; din = '0; din_valid = 1'b0; last_block = 1'b0;
      repeat (3) tick();
      chk("rst_perm_start", perm_start, 64'd0);
      chk("rst_perm_last", perm_last, 64'd0);
      chk("rst_dout_valid", dout_valid, 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_buffer_full", buffer_full, 64'd0);
      chk_blk("rst_block", block_o, '0);
      rst_n = 1'b1;
      repeat (2) tick();

      // single lane 0x61 with start and last together
      run_msg(1, 1'b1, 1'b0, 2, "A");

      // 17 counting lanes, no last: full handling, dropped 18th strobe, return to ABSORB
      exp_lanes.delete();
      for (int i = 0; i < RL; i++) exp_lanes.push_back(64'(i + 1));
      model(1'b1, 1'b1);
      for (int i = 0; i < RL; i++) drive_lane(exp_lanes[i], 1'b0, i == 0);
      chk("B_full", buffer_full, 64'd1);
      chk("B_not_ready", ready, 64'd0);
      chk("B_no_pstart_yet", perm_start, 64'd0);
      din = 64'hDEAD_BEEF_0BAD_F00D;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      din = '0;
      chk("B_pstart", perm_start, 64'd1);
      chk("B_plast", perm_last, 64'd0);
      chk("B_full_perm", buffer_full, 64'd1);
      w = 0;
      while (ready !== 1'b1 && w < 400) begin tick(); w++; end
      chk("B_back_ready", ready, 64'd1);
      chk("B_cnt0", buffer_full, 64'd0);
      chk_blk("B_cleared", block_o, '0);
      drive_last_only();
      check_blocks("B");
      check_digest("B");

      // 17 lanes with last on lane 17, then 3 lanes with last
      run_msg(17, 1'b1, 1'b0, 0, "C");
      run_msg(3, 1'b1, 1'b0, 0, "D");

      // random message lengths, last on a lane or standalone
      for (int r = 0; r < 6; r++) begin
         n = int'($urandom_range(0, 40));
         stand = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         run_msg(n, 1'b1, stand, 0, $sformatf("R%0d", r));
      end

      // abort during PERM: stale perm_done must be ignored
      perm_lat_fix = 10;
      exp_lanes.delete();
      for (int i = 0; i < RL; i++) exp_lanes.push_back({$urandom, $urandom});
      model(1'b0, 1'b0);
      for (int i = 0; i < RL; i++) drive_lane(exp_lanes[i], 1'b0, i == 0);
      w = 0;
      while (blk_q.size() < 1 && w < 100) begin tick(); w++; end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("E_ready", ready, 64'd1);
      chk("E_cnt0", buffer_full, 64'd0);
      chk_blk("E_cleared", block_o, '0);
      repeat (14) tick();
      chk("E_still_ready", ready, 64'd1);
      chk("E_no_dout", 64'(dout_q.size()), 64'd0);
      chk("E_dv", dout_valid, 64'd0);
      chk_blk("E_still_clear", block_o, '0);
      perm_lat_fix = 0;
      check_blocks("E_abort");
      exp_lanes.delete();
      for (int i = 0; i < 3; i++) exp_lanes.push_back({$urandom, $urandom});
      model(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive_lane(exp_lanes[i], i == 2, 1'b0);
      check_blocks("E_new");
      check_digest("E_new");

      // async reset in the middle of the digest stream
      exp_lanes.delete();
      for (int i = 0; i < 2; i++) exp_lanes.push_back({$urandom, $urandom});
      model(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) drive_lane(exp_lanes[i], i == 1, i == 0);
      check_blocks("F");
      seen = 0;
      w = 0;
      lane1 = '0;
      while (seen < 2 && w < 100) begin
         tick();
         w++;
         if (dout_valid === 1'b1) begin
            seen++;
            if (seen == 2) lane1 = dout;
         end
      end
      rst_n = 1'b0;
      #1;
      chk("F_seen", 64'(seen), 64'd2);
      chk("F_dv_rst", dout_valid, 64'd0);
      chk("F_dout_rst", dout, 64'd0);
      chk("F_ready_idle", ready, 64'd1);
      chk("F_full_rst", buffer_full, 64'd0);
      chk("F_pstart_rst", perm_start, 64'd0);
      chk_blk("F_block_rst", block_o, '0);
      d = (dig_q.size() > 0) ? dig_q.pop_front() : '0;
      chk("F_lane1", lane1, d[127:64]);
      chk("F_mon", 64'(dout_q.size()), 64'd1);
      if (dout_q.size() > 0) chk("F_lane0", dout_q[0], d[63:0]);
      dout_q.delete();
      dv_cyc.delete();
      dig_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("F_quiet", 64'(dout_q.size()), 64'd0);
      run_msg(1, 1'b1, 1'b0, 0, "F_restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
